// File: rtl/clock_pkg.sv
// clock_pkg: shared types for the digital-clock datapath.
//   btn_state_e : state encoding for the button event decoder.
//   cnt_width() : width of a counter that must reach the larger of two terms.
package clock_pkg;

   typedef enum logic [1:0] {
      WAIT_LOW = 2'd0,
      IDLE     = 2'd1,
      PRESSED  = 2'd2,
      HELD     = 2'd3
   } btn_state_e;

   // Width needed to hold values 0 .. max(a,b)-1, never less than 1 bit.
   function automatic int unsigned cnt_width(input int unsigned a,
                                             input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/button_events.sv
// button_events: turns a clean button level into press / release /
// long-press / auto-repeat events.
//   clk           : system clock, all logic on posedge
//   rst           : synchronous, active-high reset
//   btn           : debounced, synchronous button level (1 = pressed)
//   press         : one-cycle pulse on press
//   release_pulse : one-cycle pulse on release
//   long_press    : one-cycle pulse when the hold reaches LONG_CYCLES
//   repeat_pulse  : one-cycle pulse every RPT_CYCLES while in long hold
//   held          : level, high while in the long-hold state
// The release and repeat events carry a _pulse suffix because "release"
// and "repeat" are reserved words in SystemVerilog.
module button_events
   import clock_pkg::*;
#(
   parameter int unsigned LONG_CYCLES = 50_000_000,
   parameter int unsigned RPT_CYCLES  = 10_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press,
   output logic release_pulse,
   output logic long_press,
   output logic repeat_pulse,
   output logic held
);

   localparam int unsigned CW = cnt_width(LONG_CYCLES, RPT_CYCLES);
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0] RPT_LAST  = CW'(RPT_CYCLES - 1);

   btn_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          long_q, long_d;
   logic          repeat_q, repeat_d;
   logic          held_q, held_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      held_d    = 1'b0;
      unique case (state_q)
         // A button still down after reset must be released before it
         // can generate any event.
         WAIT_LOW: begin
            if (!btn) state_d = IDLE;
         end
         IDLE: begin
            if (btn) begin
               state_d = PRESSED;
               press_d = 1'b1;
               cnt_d   = '0;
            end
         end
         PRESSED: begin
            // Release is checked first so it wins over the threshold.
            if (!btn) begin
               state_d   = IDLE;
               release_d = 1'b1;
               cnt_d     = '0;
            end else if (cnt_q == LONG_LAST) begin
               state_d = HELD;
               long_d  = 1'b1;
               held_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HELD: begin
            if (!btn) begin
               state_d   = IDLE;
               release_d = 1'b1;
               cnt_d     = '0;
            end else begin
               held_d = 1'b1;
               if (cnt_q == RPT_LAST) begin
                  repeat_d = 1'b1;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = WAIT_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= WAIT_LOW;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         repeat_q  <= repeat_d;
         held_q    <= held_d;
      end
   end

   assign press         = press_q;
   assign release_pulse = release_q;
   assign long_press    = long_q;
   assign repeat_pulse  = repeat_q;
   assign held          = held_q;

endmodule

// File: tb/tb_button_events.sv
// Bench for button_events with LONG_CYCLES = 8, RPT_CYCLES = 4.
// A reference model samples btn/rst on every posedge and queues the output
// vector {press, release, long_press, repeat, held} expected after that edge;
// each test pops one entry per cycle and compares it with the DUT.
module tb_button_events;

   localparam int unsigned LONG = 8;
   localparam int unsigned RPT  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn = 1'b0;
   logic press, release_pulse, long_press, repeat_pulse, held;

   int unsigned total = 0;
   int unsigned bad   = 0;

   logic [4:0] sbq[$];
   logic       sb_en = 1'b0;

   button_events #(.LONG_CYCLES(LONG), .RPT_CYCLES(RPT)) dut (
      .clk(clk), .rst(rst), .btn(btn),
      .press(press), .release_pulse(release_pulse), .long_press(long_press),
      .repeat_pulse(repeat_pulse), .held(held)
   );

   always #5 clk = ~clk;

   // Reference model: armed = a low level has been seen since reset,
   // down = button is considered pressed, run = high samples since press.
   logic        m_armed = 1'b0;
   logic        m_down  = 1'b0;
   int unsigned m_run   = 0;

   always @(posedge clk) begin : model
      logic [4:0]  e;
      logic        na, nd;
      int unsigned nr;
      e  = '0;
      na = m_armed;
      nd = m_down;
      nr = m_run;
      if (rst) begin
         na = 1'b0; nd = 1'b0; nr = 0;
      end else if (!m_armed) begin
         if (!btn) na = 1'b1;
      end else if (!m_down) begin
         if (btn) begin nd = 1'b1; nr = 1; e[4] = 1'b1; end
      end else if (!btn) begin
         nd = 1'b0; nr = 0; e[3] = 1'b1;
      end else begin
         nr = m_run + 1;
         if (nr == LONG + 1) e[2] = 1'b1;
         else if (nr > LONG + 1 && ((nr - LONG - 1) % RPT) == 0) e[1] = 1'b1;
      end
      e[0] = nd && (nr > LONG);
      m_armed <= na;
      m_down  <= nd;
      m_run   <= nr;
      if (sb_en) sbq.push_back(e);
   end

   function automatic logic [4:0] outs();
      return {press, release_pulse, long_press, repeat_pulse, held};
   endfunction

   task automatic tick(input logic b, input logic r);
      @(negedge clk);
      btn = b;
      rst = r;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [4:0] exp;
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      sb_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b1);
         if (sbq.size() == 0) begin
            bad++; $display("FAIL reset: no expected entry at step %0d", i);
         end else begin
            exp = sbq.pop_front();
            total++;
            if (outs() !== exp) begin
               bad++; $display("FAIL reset step %0d: got %b want %b", i, outs(), exp);
            end
         end
      end
      // Leave the DUT armed (WAIT_LOW -> IDLE).
      tick(1'b0, 1'b0);
      if (sbq.size() != 0) void'(sbq.pop_front());
      total++;
      if (outs() !== 5'b0) begin
         bad++; $display("FAIL reset_release: got %b want %b", outs(), 5'b0);
      end
   endtask

   task automatic test_short_press();
      logic [1:0]  stim[$];
      logic [4:0]  exp;
      int unsigned np = 0, nrel = 0, nl = 0;
      int          t_press = -1, t_rel = -1;
      stim = {2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
      foreach (stim[i]) begin
         tick(stim[i][0], stim[i][1]);
         if (sbq.size() == 0) begin
            bad++; $display("FAIL short_press: no expected entry at step %0d", i);
         end else begin
            exp = sbq.pop_front();
            total++;
            if (outs() !== exp) begin
               bad++; $display("FAIL short_press step %0d: got %b want %b", i, outs(), exp);
            end
         end
         if (press) begin np++; t_press = i; end
         if (release_pulse) begin nrel++; t_rel = i; end
         if (long_press) nl++;
      end
      total++;
      if (np != 1 || nrel != 1 || nl != 0 || t_press != 2 || t_rel != 5) begin
         bad++;
         $display("FAIL short_press_events: got press=%0d@%0d rel=%0d@%0d long=%0d want 1@2 1@5 0",
                  np, t_press, nrel, t_rel, nl);
      end
   endtask

   task automatic test_long_hold();
      logic [4:0]  exp;
      int unsigned nl = 0, nrp = 0, nheld = 0;
      int          t_press = -1, t_long = -1, t_rel = -1;
      for (int i = 0; i < 23; i++) begin
         tick((i < 21) ? 1'b1 : 1'b0, 1'b0);
         if (sbq.size() == 0) begin
            bad++; $display("FAIL long_hold: no expected entry at step %0d", i);
         end else begin
            exp = sbq.pop_front();
            total++;
            if (outs() !== exp) begin
               bad++; $display("FAIL long_hold step %0d: got %b want %b", i, outs(), exp);
            end
         end
         if (press) t_press = i;
         if (long_press) begin nl++; t_long = i; end
         if (repeat_pulse) nrp++;
         if (held) nheld++;
         if (release_pulse) t_rel = i;
      end
      // 21 high samples: long at sample 9, repeats at 13, 17, 21.
      total++;
      if (t_press != 0 || t_long != 8 || nl != 1 || nrp != 3 || nheld != 13 || t_rel != 21) begin
         bad++;
         $display("FAIL long_hold_events: got press@%0d long=%0d@%0d rpt=%0d held=%0d rel@%0d want 0 1@8 3 13 21",
                  t_press, nl, t_long, nrp, nheld, t_rel);
      end
   endtask

   task automatic test_threshold_release();
      logic [4:0]  exp;
      int unsigned nl = 0, nrel = 0;
      // Count reaches LONG-1 after the 8th high sample; btn is low on the next edge.
      for (int i = 0; i < 11; i++) begin
         tick((i < 8) ? 1'b1 : 1'b0, 1'b0);
         if (sbq.size() == 0) begin
            bad++; $display("FAIL threshold: no expected entry at step %0d", i);
         end else begin
            exp = sbq.pop_front();
            total++;
            if (outs() !== exp) begin
               bad++; $display("FAIL threshold step %0d: got %b want %b", i, outs(), exp);
            end
         end
         if (long_press || held || repeat_pulse) nl++;
         if (release_pulse) nrel++;
      end
      total++;
      if (nl != 0 || nrel != 1) begin
         bad++; $display("FAIL threshold_events: got long/held=%0d rel=%0d want 0 1", nl, nrel);
      end
   endtask

   task automatic test_hold_through_reset();
      logic [4:0]  exp;
      int unsigned nev = 0, np = 0;
      int          t_press = -1;
      for (int i = 0; i < 38; i++) begin
         if (i < 2)       tick(1'b1, 1'b1);
         else if (i < 32) tick(1'b1, 1'b0);
         else if (i == 32) tick(1'b0, 1'b0);
         else             tick(1'b1, 1'b0);
         if (sbq.size() == 0) begin
            bad++; $display("FAIL hold_reset: no expected entry at step %0d", i);
         end else begin
            exp = sbq.pop_front();
            total++;
            if (outs() !== exp) begin
               bad++; $display("FAIL hold_reset step %0d: got %b want %b", i, outs(), exp);
            end
         end
         if (release_pulse || long_press || repeat_pulse || held) nev++;
         if (press) begin np++; t_press = i; end
      end
      total++;
      if (nev != 0 || np != 1 || t_press != 33) begin
         bad++; $display("FAIL hold_reset_events: got other=%0d press=%0d@%0d want 0 1@33", nev, np, t_press);
      end
      tick(1'b0, 1'b0);
      if (sbq.size() != 0) void'(sbq.pop_front());
   endtask

   task automatic test_reset_in_held();
      logic [4:0]  exp;
      int unsigned nrel = 0;
      logic        held_seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i < 11)       tick(1'b1, 1'b0);
         else if (i == 11) tick(1'b1, 1'b1);
         else              tick(1'b0, 1'b0);
         if (sbq.size() == 0) begin
            bad++; $display("FAIL reset_held: no expected entry at step %0d", i);
         end else begin
            exp = sbq.pop_front();
            total++;
            if (outs() !== exp) begin
               bad++; $display("FAIL reset_held step %0d: got %b want %b", i, outs(), exp);
            end
         end
         if (i == 10) held_seen = held;
         if (i >= 11 && release_pulse) nrel++;
      end
      total++;
      if (held_seen !== 1'b1 || nrel != 0) begin
         bad++; $display("FAIL reset_held_events: got held=%b rel=%0d want 1 0", held_seen, nrel);
      end
   endtask

   task automatic test_random();
      logic [4:0]  exp, o, prev;
      logic        b;
      int unsigned run;
      prev = '0;
      b    = 1'b0;
      run  = 0;
      for (int i = 0; i < 600; i++) begin
         if (run == 0) begin
            b   = ~b;
            run = ($urandom_range(0, 3) == 0) ? $urandom_range(9, 20) : $urandom_range(1, 5);
         end
         run--;
         tick(b, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
         o = outs();
         if (sbq.size() == 0) begin
            bad++; $display("FAIL random: no expected entry at step %0d", i);
         end else begin
            exp = sbq.pop_front();
            total++;
            if (o !== exp) begin
               bad++; $display("FAIL random step %0d: got %b want %b", i, o, exp);
            end
         end
         total++;
         if ($countones(o[4:2]) > 1 || (o[2] && o[1]) || ((o[4:1] & prev[4:1]) != 4'b0)) begin
            bad++; $display("FAIL random_pulse_shape step %0d: got %b after %b want exclusive 1-cycle pulses", i, o, prev);
         end
         prev = o;
      end
   endtask

   initial begin
      test_reset();
      test_short_press();
      test_long_hold();
      test_threshold_release();
      test_hold_through_reset();
      test_reset_in_held();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
